// File: rtl/toy_eu_ingress_buffer.sv
// Receive-side ingress FIFO between the dispatch crossbar and one execution unit.
// Dispatch has no backpressure: upstream tracks credits returned on each pop.
// A push into a full buffer without a same-cycle pop is dropped and flagged
// in a sticky overflow_err.
module toy_eu_ingress_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PLD_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instruction_vld,
    input  logic [PLD_W-1:0] instruction_pld,
    input  logic             flush,
    output logic             eu_vld,
    output logic [PLD_W-1:0] eu_pld,
    input  logic             eu_rdy,
    output logic             credit_return,
    output logic [CNT_W-1:0] free_cnt,
    output logic             empty,
    output logic             overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PLD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic push;
    logic pop;
    logic full;
    logic accept_push;

    // Handshake qualification; flush overrides both sides of the buffer
    always_comb begin
        push        = instruction_vld & ~flush;
        pop         = eu_vld & eu_rdy & ~flush;
        full        = (cnt == CNT_W'(DEPTH));
        // A full buffer still accepts a push when the head leaves on the same edge
        accept_push = push & (~full | pop);
    end

    // Status and head outputs derived from registered state
    always_comb begin
        eu_vld        = (cnt != '0);
        empty         = (cnt == '0);
        free_cnt      = CNT_W'(DEPTH) - cnt;
        credit_return = pop;
        // Gated so the payload reads zero while nothing valid is held
        eu_pld        = eu_vld ? mem[rd_ptr] : '0;
    end

    // Entry storage; intentionally not reset
    always_ff @(posedge clk) begin
        if (accept_push) begin
            mem[wr_ptr] <= instruction_pld;
        end
    end

    // Pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                overflow_err <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (accept_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (accept_push && !pop) begin
                    cnt <= cnt + 1'b1;
                end else if (pop && !accept_push) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/toy_eu_ingress_buffer.md
Name: toy_eu_ingress_buffer

Overview:
- Receive-side endpoint of the dispatch-crossbar-to-EU interface (valid + eu_pkg, no backpressure toward dispatch).
- One instance per execution unit (mext, float, csr, custom).
- Captures every dispatched eu_pkg into an in-order FIFO and presents it to the EU through a valid/ready handshake.
- Returns one credit per consumed entry so upstream issue logic never dispatches into a full buffer.

Parameters:
DEPTH, 4, number of buffered eu_pkg entries (power of 2, >=2)
CNT_W, $clog2(DEPTH+1), width of occupancy/free counters

Ports:
clk  input  1  core clock
rst_n  input  1  reset; asynchronous, active-low
instruction_vld  input  1  dispatch valid from crossbar (no ready returned)
instruction_pld  input  $bits(eu_pkg)  dispatched eu_pkg payload
flush  input  1  pipeline flush/cancel; discards all buffered entries
eu_vld  output  1  head entry valid toward EU
eu_pld  output  $bits(eu_pkg)  head entry payload
eu_rdy  input  1  EU accepts head entry
credit_return  output  1  one-cycle pulse per entry popped by EU
free_cnt  output  CNT_W  free entries (DEPTH - occupancy)
empty  output  1  occupancy == 0
overflow_err  output  1  sticky: push attempted with no free entry

Behaviour:
- Storage: DEPTH-entry register array; wr_ptr, rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy counter cnt of CNT_W bits.
- Reset (async assert, rst_n=0):
  - wr_ptr=0, rd_ptr=0, cnt=0, overflow_err=0.
  - Outputs: eu_vld=0, credit_return=0, free_cnt=DEPTH, empty=1, eu_pld=0.
  - Entry array is not reset.
- Reset deassertion is synchronised externally. First push is legal on the first clk edge after release.
- push = instruction_vld & ~flush.
- pop = eu_vld & eu_rdy & ~flush.
- Push:
  - Written at wr_ptr on the clk edge; wr_ptr++.
  - Latency 1: the entry is visible on eu_vld/eu_pld in the cycle after instruction_vld, earliest.
  - No same-cycle bypass.
- Pop:
  - rd_ptr++ on the edge.
  - credit_return = pop, combinational, same cycle as the handshake.
- eu_vld = (cnt != 0); eu_pld = array[rd_ptr], registered-array read.
- eu_pld is held stable while eu_vld=1 and eu_rdy=0.
- cnt update: push&~pop -> +1; pop&~push -> -1; both or neither -> unchanged.
- Full (cnt==DEPTH):
  - push & pop in the same cycle is accepted (slot freed the same edge); cnt stays DEPTH.
  - push & ~pop: payload dropped, pointers and cnt unchanged, overflow_err set.
  - overflow_err remains set until reset; flush does not clear it.
- Empty (cnt==0): eu_rdy is ignored; no pop, no credit.
- Flush:
  - wr_ptr=rd_ptr=0, cnt=0 on the edge.
  - Same-cycle instruction_vld is discarded; same-cycle eu_rdy does not pop.
  - credit_return=0 during flush.
  - Upstream resets its credit count to DEPTH on flush; free_cnt reads DEPTH the following cycle.
- free_cnt = DEPTH - cnt, combinational from the registered cnt.
- Ordering: strict FIFO; entries leave in dispatch order.

Test Plan:
1. Reset, then push 3 entries (inst_id 1,2,3) on consecutive cycles, eu_rdy=1 -> eu_vld rises the cycle after the first push; ids pop 1,2,3; three credit_return pulses; free_cnt returns to 4; empty=1.
2. eu_rdy=0, push 4 entries -> free_cnt=0, eu_pld held at id1 over 10 cycles. Then push id5 with eu_rdy=0 -> dropped, overflow_err=1 and stays 1; subsequent pops yield ids 1-4 only.
3. Full buffer: push id9 with eu_rdy=1 in the same cycle -> id1 popped, id9 accepted, cnt stays 4, credit_return=1, overflow_err unchanged (0 after fresh reset).
4. 2 entries buffered: flush together with instruction_vld and eu_rdy -> no credit pulse; next cycle eu_vld=0, free_cnt=4, empty=1. Post-flush push id7 appears alone.
5. 3 entries buffered, rst_n pulled low mid-cycle -> immediately eu_vld=0, free_cnt=4, overflow_err=0. After release, pointer wrap test: 20 push/pop pairs with random eu_rdy -> in-order ids, credits equal pops, free_cnt never exceeds 4.
